mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MUL_CYCLES, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  E-stage MULT/MULTU/DIV/DIVU issue strobe, one cycle per instruction.
REQ-006 Port md_op  input  3  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, NONE.
REQ-007 Port rs_val  input  32  forwarded rs operand in E.
REQ-008 Port rt_val  input  32  forwarded rt operand in E.
REQ-009 Port d_md_use  input  1  D-stage instruction is any MDU op (incl. MFHI/MFLO/MTHI/MTLO).
REQ-010 Port busy  output  1  multi-cycle operation in progress.
REQ-011 Port stall_req  output  1  request to freeze PC/IF-ID and bubble ID-EX.
REQ-012 Port md_rd  output  32  HI when md_op=MFHI, LO when md_op=MFLO, else 0.

Function
REQ-013 Block SHALL hold states IDLE, MUL, DIV and a countdown counter cnt wide enough for DIV_CYCLES.
REQ-014 IDLE + start + MULT/MULTU SHALL latch operands, compute 64-bit product (signed/unsigned per op), load cnt=MUL_CYCLES, go MUL.
REQ-015 IDLE + start + DIV/DIVU SHALL latch operands, compute quotient/remainder (signed/unsigned, truncating toward zero), load cnt=DIV_CYCLES, go DIV.
REQ-016 In MUL/DIV cnt SHALL decrement each cycle; on the cycle cnt reaches 1 the result SHALL be written (HI=product[63:32]/remainder, LO=product[31:0]/quotient) and state SHALL return to IDLE.
REQ-017 busy SHALL be 1 exactly while state is MUL or DIV, i.e. for MUL_CYCLES (or DIV_CYCLES) cycles starting the cycle after start.
REQ-018 HI/LO SHALL hold old values throughout busy; new values visible on md_rd the cycle after busy falls.
REQ-019 DIV/DIVU with rt_val=0 SHALL run full DIV_CYCLES and leave HI/LO unchanged.
REQ-020 MTHI/MTLO in IDLE SHALL write rs_val to HI/LO at the next edge (single cycle, no busy).
REQ-021 start or MTHI/MTLO while busy SHALL be ignored (protocol violation; pipeline stall prevents it).
REQ-022 md_rd SHALL be combinational from HI/LO and md_op.
REQ-023 stall_req SHALL equal d_md_use AND (start OR busy).
REQ-024 start with md_op not MULT/MULTU/DIV/DIVU SHALL be ignored.
REQ-025 Signed DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.

Reset
REQ-026 reset SHALL set state=IDLE, cnt=0, HI=0, LO=0, busy=0, latched operands=0, overriding start in the same cycle.
REQ-027 reset during MUL/DIV SHALL abort the operation with no HI/LO update.
REQ-028 After reset release stall_req=0 and md_rd=0 until driven otherwise.

Structure
REQ-029 md_op encodings and MUL_CYCLES/DIV_CYCLES defaults SHALL live in the shared CPU constants package used by the decoder.
REQ-030 Arithmetic SHALL be a sub-module mdu_arith (combinational: op, a, b -> hi, lo, div_by_zero); mdu_ctrl owns the FSM, counter and HI/LO registers.

Verification
REQ-031 MULT rs=0xFFFFFFFE (-2), rt=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 DIVU rs=100, rt=7 -> busy high 10 cycles, then HI=2, LO=14; MFLO during busy returns old LO.
REQ-033 DIV rs=5, rt=0 with HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO remain 0x11/0x22.
REQ-034 MULTU followed next cycle by d_md_use=1 (MFHI) -> stall_req high on start cycle and all 5 busy cycles, low after; MFHI then returns new HI.
REQ-035 reset asserted on 3rd busy cycle of DIV -> next cycle busy=0, HI=LO=0, no late result write.
REQ-036 MTHI rs=0xDEADBEEF in IDLE then MFHI -> md_rd=0xDEADBEEF one cycle later, busy never asserted.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - shared CPU constants for the multiply/divide unit
//
// md_op encodings and default busy lengths, shared with the decoder.
// There are nine op names but only eight 3-bit codes, so MD_NONE aliases MD_MULT.
// This is harmless because MULT only acts together with start.
// A NONE code on an idle pipeline slot is always driven with start=0.
package mdu_ctrl_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MFHI  = 3'd6;
  localparam logic [2:0] MD_MFLO  = 3'd7;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  // Ops that launch a multi-cycle operation when paired with start.
  function automatic logic is_md_start_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_md_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide datapath for the MDU
//
// Ports:
//   op          in   3   MULT/MULTU/DIV/DIVU selects the operation
//   a, b        in  32   operands (rs, rt)
//   hi, lo      out 32   product[63:32]/[31:0], or remainder/quotient
//   div_by_zero out  1   DIV/DIVU with b == 0 (hi/lo are then don't-care)
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [63:0] prod_mag;
  logic [63:0] prod;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Signed operations run on magnitudes and fix the signs afterwards.
  // As a result, 0x80000000 / -1 wraps to 0x80000000 with no special case.
  // Truncation toward zero comes from the unsigned divide on the magnitudes.
  // The remainder takes the sign of the dividend.
  always_comb begin
    signed_op   = (op == MD_MULT) || (op == MD_DIV);
    a_neg       = signed_op & a[31];
    b_neg       = signed_op & b[31];
    a_mag       = a_neg ? (32'd0 - a) : a;
    b_mag       = b_neg ? (32'd0 - b) : b;

    prod_mag    = {32'd0, a_mag} * {32'd0, b_mag};
    prod        = (a_neg ^ b_neg) ? (64'd0 - prod_mag) : prod_mag;

    div_by_zero = is_md_div_op(op) && (b == 32'd0);
    q_mag       = 32'd0;
    r_mag       = 32'd0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem         = a_neg ? (32'd0 - r_mag) : r_mag;

    if (is_md_div_op(op)) begin
      hi = rem;
      lo = quot;
    end else begin
      hi = prod[63:32];
      lo = prod[31:0];
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit control: FSM, busy counter, HI/LO
//
// Ports:
//   clk, reset   in   1   rising-edge clock, synchronous active-high reset
//   start        in   1   E-stage MULT/MULTU/DIV/DIVU issue strobe
//   md_op        in   3   MDU operation code (mdu_ctrl_pkg encodings)
//   rs_val       in  32   forwarded rs operand
//   rt_val       in  32   forwarded rt operand
//   d_md_use     in   1   D-stage instruction uses the MDU
//   busy         out  1   multi-cycle operation in progress
//   stall_req    out  1   freeze PC/IF-ID and bubble ID-EX
//   md_rd        out 32   HI for MFHI, LO for MFLO, else 0
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] md_rd
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [2:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_dbz;

  // The arithmetic runs on the latched operands.
  // The result therefore stays stable for the whole busy window.
  // It is committed only on the final busy cycle.
  mdu_arith u_arith (
    .op          (op_q),
    .a           (a_q),
    .b           (b_q),
    .hi          (res_hi),
    .lo          (res_lo),
    .div_by_zero (res_dbz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
      op_q  <= MD_NONE;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && is_md_start_op(md_op)) begin
            op_q  <= md_op;
            a_q   <= rs_val;
            b_q   <= rt_val;
            cnt   <= is_md_div_op(md_op) ? DIV_CNT : MUL_CNT;
            state <= is_md_div_op(md_op) ? ST_DIV : ST_MUL;
          end else if (md_op == MD_MTHI) begin
            hi_q <= rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_q <= rs_val;
          end
        end
        ST_MUL, ST_DIV: begin
          // Start and MTHI/MTLO are deliberately ignored here.
          // The pipeline stall keeps them from arriving while busy.
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= ST_IDLE;
            if (!res_dbz) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == ST_MUL) || (state == ST_DIV);
    stall_req = d_md_use & (start | busy);
    md_rd     = 32'd0;
    if (md_op == MD_MFHI) begin
      md_rd = hi_q;
    end else if (md_op == MD_MFLO) begin
      md_rd = lo_q;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard testbench for mdu_ctrl
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int T_MUL = 5;
  localparam int T_DIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = MD_NONE;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        d_md_use = 1'b0;
  logic        busy;
  logic        stall_req;
  logic [31:0] md_rd;

  mdu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_md_use  (d_md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .md_rd     (md_rd)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  logic        checking = 1'b0;
  logic        exp_busy = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] exp_q[$];

  // Architectural reference: what HI/LO must become after an operation.
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic wr);
    longint          sa;
    longint          sb;
    longint          p;
    longint          q;
    longint          r;
    longint unsigned up;
    hi = 32'd0;
    lo = 32'd0;
    wr = 1'b1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: begin
        p  = sa * sb;
        hi = p[63:32];
        lo = p[31:0];
      end
      MD_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      MD_DIV: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end
      end
      default: begin
        if (b == 32'd0) wr = 1'b0;
        else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endfunction

  // One pipeline cycle of stimulus; eb is whether the unit must read busy in it.
  task automatic step(input logic rst, input logic st, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic use_d, input logic eb);
    @(posedge clk);
    #1;
    reset    = rst;
    start    = st;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    d_md_use = use_d;
    exp_busy = eb;
    if (op == MD_MFHI) exp_q.push_back(m_hi);
    else if (op == MD_MFLO) exp_q.push_back(m_lo);
  endtask

  task automatic idle(input logic use_d);
    step(1'b0, 1'b0, MD_NONE, 32'd0, 32'd0, use_d, 1'b0);
  endtask

  task automatic read_both();
    step(1'b0, 1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic write_hl(input logic to_hi, input logic [31:0] v);
    step(1'b0, 1'b0, to_hi ? MD_MTHI : MD_MTLO, v, 32'd0, 1'b0, 1'b0);
    if (to_hi) m_hi = v;
    else m_lo = v;
  endtask

  // Issue one MULT/MULTU/DIV/DIVU, optionally reading and poking illegal ops while busy.
  // A nonzero abort_at asserts reset on that busy cycle.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic reads, input logic junk, input int abort_at);
    logic [31:0] nh;
    logic [31:0] nl;
    logic        wr;
    int          n;
    ref_md(op, a, b, nh, nl, wr);
    n = is_md_div_op(op) ? T_DIV : T_MUL;
    step(1'b0, 1'b1, op, a, b, use_d, 1'b0);
    for (int i = 1; i <= n; i++) begin
      if (i == abort_at) begin
        step(1'b1, 1'b0, MD_NONE, 32'd0, 32'd0, use_d, 1'b1);
        m_hi = 32'd0;
        m_lo = 32'd0;
        return;
      end
      if (junk && i == 2) step(1'b0, 1'b0, MD_MTHI, 32'hBAD0_BAD0, 32'd0, use_d, 1'b1);
      else if (junk && i == 3) step(1'b0, 1'b1, MD_MULTU, 32'h1234_5678, 32'h9, use_d, 1'b1);
      else if (reads) step(1'b0, 1'b0, (i % 2) ? MD_MFLO : MD_MFHI, 32'd0, 32'd0, use_d, 1'b1);
      else step(1'b0, 1'b0, MD_NONE, 32'd0, 32'd0, use_d, 1'b1);
    end
    if (wr) begin
      m_hi = nh;
      m_lo = nl;
    end
  endtask

  // Monitor: compares DUT outputs every cycle, popping expected md_rd values for reads.
  always @(negedge clk) begin
    if (checking) begin
      n_checks++;
      if (busy !== exp_busy) begin
        n_err++;
        $display("FAIL busy: got %0b want %0b at %0t", busy, exp_busy, $time);
      end
      n_checks++;
      if (stall_req !== (d_md_use & (start | exp_busy))) begin
        n_err++;
        $display("FAIL stall_req: got %0b want %0b at %0t", stall_req, d_md_use & (start | exp_busy), $time);
      end
      if (md_op == MD_MFHI || md_op == MD_MFLO) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL md_rd_queue: read with no expectation at %0t", $time);
        end else begin
          logic [31:0] ev;
          ev = exp_q.pop_front();
          if (md_rd !== ev) begin
            n_err++;
            $display("FAIL md_rd(op=%0d): got %08h want %08h at %0t", md_op, md_rd, ev, $time);
          end
        end
      end else begin
        n_checks++;
        if (md_rd !== 32'd0) begin
          n_err++;
          $display("FAIL md_rd_zero: got %08h want 00000000 at %0t", md_rd, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;

    // Reset state: nothing busy, no stall, HI/LO read as zero.
    idle(1'b1);
    read_both();

    // MULT -2 * 3.
    run_md(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0, 0);
    read_both();

    // DIVU 100 / 7 with MFLO/MFHI during busy returning old values.
    run_md(MD_DIVU, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 0);
    read_both();

    // Divide by zero leaves HI/LO untouched.
    write_hl(1'b1, 32'h11);
    write_hl(1'b0, 32'h22);
    run_md(MD_DIV, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0, 0);
    read_both();

    // MULTU with a dependent MFHI in D: stall on start and every busy cycle.
    run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, MD_MFHI, 32'd0, 32'd0, 1'b1, 1'b0);
    read_both();

    // Reset on the third busy cycle of DIV aborts with no late write.
    run_md(MD_DIV, 32'd1000, 32'd3, 1'b0, 1'b0, 1'b0, 3);
    repeat (12) idle(1'b0);
    read_both();

    // MTHI then MFHI next cycle.
    write_hl(1'b1, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);

    // Signed overflow case.
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
    read_both();

    // start with non-arith codes is ignored; illegal ops while busy are ignored.
    step(1'b0, 1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, MD_MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
    run_md(MD_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 1'b1, 0);
    read_both();

    // Randomized operations and operands.
    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'd0 - 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) write_hl(1'($urandom_range(0, 1)), $urandom);
      run_md(rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 0);
      read_both();
    end
    idle(1'b0);

    @(negedge clk);
    #1;
    checking = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected reads left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
